tilelink_ul_slave_mem: RTL

TileLink UL responder (slave) for the low-speed peripheral domain, the D-channel-driving end facing `tilelink_master_top`-style initiators. Accepts single-beat Get, PutFullData and PutPartialData on channel A, services them from an internal byte-maskable word memory, and returns AccessAck/AccessAckData on channel D. One outstanding transaction at a time.

---
 rtl/tl_ul_pkg.sv | 25 ++
 rtl/tilelink_slave_mem_array.sv | 35 +++
 rtl/tilelink_ul_slave_mem.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/tl_ul_pkg.sv
// Shared TileLink UL definitions: channel A/D opcodes, responder FSM states, legal-size helper.
package tl_ul_pkg;

  // Channel A opcodes
  localparam logic [2:0] OpPutFullData    = 3'd0;
  localparam logic [2:0] OpPutPartialData = 3'd1;
  localparam logic [2:0] OpGet            = 3'd4;

  // Channel D opcodes
  localparam logic [2:0] OpAccessAck      = 3'd0;
  localparam logic [2:0] OpAccessAckData  = 3'd1;

  typedef enum logic [0:0] {
    StIdle,
    StRespond
  } tl_state_e;

  // Largest a_size (log2 bytes) a single beat may carry on a bus with this many byte lanes.
  function automatic int unsigned tl_max_size(input int unsigned strb_width);
    return $clog2(strb_width);
  endfunction

  localparam int unsigned TlMaxSize64 = 3;

endpackage

// File: rtl/tilelink_slave_mem_array.sv
// Byte-maskable word memory: synchronous masked write, combinational read, synchronous clear.
module tilelink_slave_mem_array #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [IDX_W-1:0]      addr,
  input  logic [STRB_WIDTH-1:0] wmask,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int w = 0; w < int'(DEPTH); w++) begin
        mem_q[w] <= '0;
      end
    end else if (we) begin
      for (int b = 0; b < int'(STRB_WIDTH); b++) begin
        if (wmask[b]) begin
          mem_q[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/tilelink_ul_slave_mem.sv
// TileLink UL single-outstanding memory responder. Define TL_SLAVE_DENIED_EN to range-check
// requests and flag illegal ones with d_error; otherwise addresses alias and d_error stays 0.
module tilelink_ul_slave_mem
  import tl_ul_pkg::*;
#(
  parameter int unsigned                 TL_ADDR_WIDTH   = 64,
  parameter int unsigned                 TL_DATA_WIDTH   = 64,
  parameter int unsigned                 TL_STRB_WIDTH   = TL_DATA_WIDTH / 8,
  parameter int unsigned                 TL_SOURCE_WIDTH = 3,
  parameter int unsigned                 TL_SINK_WIDTH   = 3,
  parameter int unsigned                 TL_OPCODE_WIDTH = 3,
  parameter int unsigned                 TL_PARAM_WIDTH  = 3,
  parameter int unsigned                 TL_SIZE_WIDTH   = 8,
  parameter int unsigned                 DEPTH           = 16,
  parameter logic [TL_ADDR_WIDTH-1:0]    BASE_ADDR       = '0,
  parameter logic [TL_SINK_WIDTH-1:0]    SINK_ID         = '0
) (
  input  logic                       clk,
  input  logic                       rst,

  input  logic                       a_valid,
  output logic                       a_ready,
  input  logic [TL_OPCODE_WIDTH-1:0] a_opcode,
  input  logic [TL_PARAM_WIDTH-1:0]  a_param,
  input  logic [TL_ADDR_WIDTH-1:0]   a_address,
  input  logic [TL_SIZE_WIDTH-1:0]   a_size,
  input  logic [TL_STRB_WIDTH-1:0]   a_mask,
  input  logic [TL_DATA_WIDTH-1:0]   a_data,
  input  logic [TL_SOURCE_WIDTH-1:0] a_source,

  output logic                       d_valid,
  input  logic                       d_ready,
  output logic [TL_OPCODE_WIDTH-1:0] d_opcode,
  output logic [TL_PARAM_WIDTH-1:0]  d_param,
  output logic [TL_SIZE_WIDTH-1:0]   d_size,
  output logic [TL_SINK_WIDTH-1:0]   d_sink,
  output logic [TL_SOURCE_WIDTH-1:0] d_source,
  output logic [TL_DATA_WIDTH-1:0]   d_data,
  output logic                       d_error
);

  localparam int unsigned ByteOffW = $clog2(TL_STRB_WIDTH);
  localparam int unsigned IdxW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned MaxSize  = tl_max_size(TL_STRB_WIDTH);

  // ---------------------------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------------------------
  logic [IdxW-1:0] word_idx;
  logic            in_range;
  logic            is_get;
  logic            is_put;
  logic            op_ok;
  logic            size_ok;
  logic            legal;
  logic            unused_sig;

`ifdef TL_SLAVE_DENIED_EN
  localparam logic [TL_ADDR_WIDTH-1:0] RangeBytes = TL_ADDR_WIDTH'(DEPTH * TL_STRB_WIDTH);

  // Extra top bit holds the borrow, so addresses below BASE_ADDR show up as out of range.
  logic [TL_ADDR_WIDTH:0] addr_off;

  assign addr_off   = {1'b0, a_address} - {1'b0, BASE_ADDR};
  assign word_idx   = addr_off[ByteOffW +: IdxW];
  assign in_range   = !addr_off[TL_ADDR_WIDTH] && (addr_off[TL_ADDR_WIDTH-1:0] < RangeBytes);
  assign unused_sig = ^{a_param, addr_off};
`else
  // BASE_ADDR is aligned to the array size, so the low address bits already select the word.
  assign word_idx   = a_address[ByteOffW +: IdxW];
  assign in_range   = 1'b1;
  assign unused_sig = ^{a_param, a_address};
`endif

  assign is_get  = (a_opcode == TL_OPCODE_WIDTH'(OpGet));
  assign is_put  = (a_opcode == TL_OPCODE_WIDTH'(OpPutFullData)) ||
                   (a_opcode == TL_OPCODE_WIDTH'(OpPutPartialData));
  assign op_ok   = is_get || is_put;
  assign size_ok = (a_size <= TL_SIZE_WIDTH'(MaxSize));
  assign legal   = op_ok && size_ok && in_range;

  // ---------------------------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------------------------
  tl_state_e state_q, state_d;
  logic      load;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_ready = 1'b0;
    d_valid = 1'b0;
    load    = 1'b0;
    unique case (state_q)
      StIdle: begin
        a_ready = 1'b1;
        if (a_valid) begin
          load    = 1'b1;
          state_d = StRespond;
        end
      end
      StRespond: begin
        d_valid = 1'b1;
        if (d_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------------------------
  logic                     mem_we;
  logic [TL_DATA_WIDTH-1:0] mem_rdata;

  assign mem_we = load && legal && is_put;

  tilelink_slave_mem_array #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (TL_DATA_WIDTH),
    .STRB_WIDTH (TL_STRB_WIDTH),
    .IDX_W      (IdxW)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we),
    .addr  (word_idx),
    .wmask (a_mask),
    .wdata (a_data),
    .rdata (mem_rdata)
  );

  // ---------------------------------------------------------------------------------------------
  // D channel response registers
  // ---------------------------------------------------------------------------------------------
  logic [TL_OPCODE_WIDTH-1:0] d_opcode_q;
  logic [TL_SIZE_WIDTH-1:0]   d_size_q;
  logic [TL_SOURCE_WIDTH-1:0] d_source_q;
  logic [TL_DATA_WIDTH-1:0]   d_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      d_opcode_q <= '0;
      d_size_q   <= '0;
      d_source_q <= '0;
      d_data_q   <= '0;
    end else if (load) begin
      d_opcode_q <= is_get ? TL_OPCODE_WIDTH'(OpAccessAckData) : TL_OPCODE_WIDTH'(OpAccessAck);
      d_size_q   <= a_size;
      d_source_q <= a_source;
      d_data_q   <= (is_get && legal) ? mem_rdata : '0;
    end
  end

`ifdef TL_SLAVE_DENIED_EN
  logic d_error_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      d_error_q <= 1'b0;
    end else if (load) begin
      d_error_q <= !legal;
    end
  end

  assign d_error = d_error_q;
`else
  assign d_error = 1'b0;
`endif

  assign d_opcode = d_opcode_q;
  assign d_param  = '0;
  assign d_size   = d_size_q;
  assign d_sink   = SINK_ID;
  assign d_source = d_source_q;
  assign d_data   = d_data_q;

endmodule
